// File: rtl/araddr_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : araddr_fifo_pkg
//  Brief    : Shared sizing constants and level type for the ARADDR FIFO.
//  Revision : 1.0 - initial portable replacement of the vendor FIFO IP
// ============================================================================
package araddr_fifo_pkg;

   localparam int FIFO_DATA_W  = 32;
   localparam int FIFO_DEPTH_W = 11;
   localparam int FIFO_DEPTH   = 2048;
   localparam int AF_NUM       = 1020;
   localparam int AE_NUM       = 4;

   // One extra bit over the address so that 0 (empty) and 2048 (full) differ
   typedef logic [FIFO_DEPTH_W:0] fifo_level_t;

endpackage : araddr_fifo_pkg
`default_nettype wire

// File: rtl/sdp_ram_2048x32.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_ram_2048x32
//  Brief    : Simple dual-port RAM, synchronous write, registered read.
//             Storage is never reset; only the read register is cleared.
//  Revision : 1.0 - initial portable replacement of the vendor FIFO IP
// ============================================================================
module sdp_ram_2048x32
   import araddr_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_W,
   parameter int ADDR_WIDTH = FIFO_DEPTH_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int C_WORDS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:C_WORDS-1];
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [DATA_WIDTH-1:0] rdata_q;

   // Write port: store the word at the write address
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read data only advances on a read; otherwise the last word is held
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // Read register, cleared so the output is defined straight out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule : sdp_ram_2048x32
`default_nettype wire

// File: rtl/araddr_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : araddr_sync_fifo
//  Brief    : Single-clock 2048x32 FIFO buffering AXI ARADDR words, with
//             fill level and almost-full / almost-empty flags.
//  Revision : 1.0 - initial portable replacement of the vendor FIFO IP
// ============================================================================
module araddr_sync_fifo
   import araddr_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = FIFO_DATA_W,
   parameter int DEPTH_WIDTH      = FIFO_DEPTH_W,
   parameter int ALMOST_FULL_NUM  = AF_NUM,
   parameter int ALMOST_EMPTY_NUM = AE_NUM
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   wr_en,
   output logic                   wr_full,
   output logic [DEPTH_WIDTH:0]   wr_water_level,
   output logic                   almost_full,
   output logic [DATA_WIDTH-1:0]  rd_data,
   input  logic                   rd_en,
   output logic                   rd_empty,
   output logic [DEPTH_WIDTH:0]   rd_water_level,
   output logic                   almost_empty
);

   localparam logic [DEPTH_WIDTH:0] C_DEPTH = (DEPTH_WIDTH + 1)'(1 << DEPTH_WIDTH);
   localparam logic [DEPTH_WIDTH:0] C_AF    = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
   localparam logic [DEPTH_WIDTH:0] C_AE    = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

   logic [DEPTH_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
   logic [DEPTH_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
   logic [DEPTH_WIDTH:0]   count_d,  count_q;
   logic                   wr_accept;
   logic                   rd_accept;

   // Requests are gated by the current registered flags, so a write at full
   // or a read at empty is dropped even when the other side fires together
   assign wr_accept = wr_en & ~wr_full;
   assign rd_accept = rd_en & ~rd_empty;

   // Next-state for pointers and level; pointers wrap naturally at 2**DEPTH_WIDTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and level registers; reset discards all contents at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Flags and levels are pure decodes of the registered level
   assign wr_full        = (count_q == C_DEPTH);
   assign rd_empty       = (count_q == '0);
   assign almost_full    = (count_q >= C_AF);
   assign almost_empty   = (count_q <= C_AE);
   assign wr_water_level = count_q;
   assign rd_water_level = count_q;

   sdp_ram_2048x32 #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_accept),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .re    (rd_accept),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

endmodule : araddr_sync_fifo
`default_nettype wire

// File: tb/tb_araddr_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_araddr_sync_fifo
//  Brief    : Scoreboard bench for araddr_sync_fifo.
//  Revision : 1.0 - initial
// ============================================================================
module tb_araddr_sync_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        rd_en;
   logic        wr_full;
   logic [11:0] wr_water_level;
   logic        almost_full;
   logic [31:0] rd_data;
   logic        rd_empty;
   logic [11:0] rd_water_level;
   logic        almost_empty;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   int          m_lvl;
   logic [31:0] m_rd;

   always #5 clk = ~clk;

   araddr_sync_fifo dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_full        (wr_full),
      .wr_water_level (wr_water_level),
      .almost_full    (almost_full),
      .rd_data        (rd_data),
      .rd_en          (rd_en),
      .rd_empty       (rd_empty),
      .rd_water_level (rd_water_level),
      .almost_empty   (almost_empty)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed=0x%08h expected=0x%08h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Packed status: {4'b0, full, empty, afull, aempty, wr_level, rd_level}
   function automatic logic [31:0] exp_status(input int lvl);
      logic [11:0] l;
      l = 12'(lvl);
      return {4'b0, lvl == 2048, lvl == 0, lvl >= 1020, lvl <= 4, l, l};
   endfunction

   function automatic logic [31:0] obs_status();
      return {4'b0, wr_full, rd_empty, almost_full, almost_empty, wr_water_level, rd_water_level};
   endfunction

   // One clock: drive at negedge, update model, check 1 ns after posedge
   task automatic cycle(input string tag, input logic we, input logic [31:0] wd, input logic re);
      bit wa, ra;
      @(negedge clk);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      wa = we && (m_lvl != 2048);
      ra = re && (m_lvl != 0);
      if (ra) m_rd = sb_q.pop_front();
      if (wa) sb_q.push_back(wd);
      m_lvl = m_lvl + (wa ? 1 : 0) - (ra ? 1 : 0);
      @(posedge clk);
      #1;
      check_val({tag, "_rd_data"}, rd_data, m_rd);
      check_val({tag, "_status"}, obs_status(), exp_status(m_lvl));
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_lvl = 0;
      m_rd  = '0;
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;
      model_reset();
      #200;
      rst_n = 1'b1;
      #1;
      check_val("reset_status", obs_status(), exp_status(0));
      check_val("reset_rd_data", rd_data, 32'h0);

      // Fill with a descending pattern; the 2049th write must be dropped
      for (int i = 0; i < 2049; i++) cycle("fill", 1'b1, 32'hFFFF_FFFF - 32'(i), 1'b0);
      check_val("full_level", {20'h0, wr_water_level}, 32'd2048);
      check_val("full_flag", {31'h0, wr_full}, 32'd1);

      // Drain everything plus one extra read at empty
      for (int i = 0; i < 2049; i++) cycle("drain", 1'b0, 32'h0, 1'b1);
      check_val("drain_last", rd_data, 32'hFFFF_F800);
      check_val("drain_empty", {31'h0, rd_empty}, 32'd1);

      // Park the pointers near the top so the concurrent phase crosses the wrap
      for (int i = 0; i < 2043; i++) cycle("park_w", 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
      for (int i = 0; i < 2043; i++) cycle("park_r", 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++)    cycle("lvl5", 1'b1, 32'hB000_0000 + 32'(i), 1'b0);
      for (int i = 0; i < 10; i++)   cycle("both", 1'b1, 32'hC000_0000 + 32'(i), 1'b1);
      check_val("both_level", {20'h0, rd_water_level}, 32'd5);
      for (int i = 0; i < 5; i++)    cycle("both_drain", 1'b0, 32'h0, 1'b1);

      // At full, simultaneous request: read wins, write dropped
      for (int i = 0; i < 2048; i++) cycle("fill2", 1'b1, 32'hD000_0000 + 32'(i), 1'b0);
      cycle("full_both", 1'b1, 32'hEEEE_EEEE, 1'b1);
      check_val("full_both_data", rd_data, 32'hD000_0000);
      check_val("full_both_level", {20'h0, wr_water_level}, 32'd2047);
      for (int i = 0; i < 2047; i++) cycle("drain2", 1'b0, 32'h0, 1'b1);

      // At empty, simultaneous request: write wins, rd_data unchanged
      cycle("empty_both", 1'b1, 32'h5A5A_5A5A, 1'b1);
      check_val("empty_both_data", rd_data, 32'hD000_07FF);
      check_val("empty_both_level", {20'h0, wr_water_level}, 32'd1);
      cycle("empty_both_rd", 1'b0, 32'h0, 1'b1);
      check_val("empty_both_word", rd_data, 32'h5A5A_5A5A);

      // Asynchronous reset in the middle of a write burst
      for (int i = 0; i < 100; i++) cycle("burst", 1'b1, 32'h7000_0000 + 32'(i), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("async_rst_status", obs_status(), exp_status(0));
      check_val("async_rst_rd_data", rd_data, 32'h0);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_w", 1'b1, 32'h1234_5678, 1'b0);
      cycle("post_r", 1'b0, 32'h0, 1'b1);
      check_val("post_word", rd_data, 32'h1234_5678);
      cycle("idle", 1'b0, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_araddr_sync_fifo
`default_nettype wire
